// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response port shared between the load/store stage and the memory.
// The stage drives the request side through the master modport; the memory uses the slave modport.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Load/store stage after the execute ALU: issues data-memory accesses, stalls EX while one is
// outstanding, and presents registered writeback results (extended load data or ALU passthrough).
module mem_stage #(
  parameter int DMEM_LATENCY_MIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [32:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [1:0]  ex_mem_op,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wb_en,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_nxt;

  logic accept, is_store, is_mem, misal_now, start_mem;

  logic [31:0] addr_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [4:0]  rd_p0;
  logic        wb_en_p0;
  logic        we_p0;
  logic [3:0]  be_p0;
  logic [31:0] wdata_p0;

  logic        vld_p1;
  logic        mis_p1;
  logic        wb_en_p1;
  logic [4:0]  wb_rd_p1;
  logic [31:0] wb_data_p1;

  // Bit 32 of the ALU result and the latency parameter carry no logic.
  logic unused;
  assign unused = &{1'b0, ex_alu_result[32], DMEM_LATENCY_MIN[0]};

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] rdata);
    logic        [31:0] shifted;
    logic signed [31:0] ext;
    shifted = rdata >> {off, 3'b000};
    case (size)
      2'b00: begin
        ext = 32'(signed'(shifted[7:0]));
        return uns ? {24'b0, shifted[7:0]} : ext;
      end
      2'b01: begin
        ext = 32'(signed'(shifted[15:0]));
        return uns ? {16'b0, shifted[15:0]} : ext;
      end
      default: return shifted;
    endcase
  endfunction

  assign accept    = ex_valid & ex_ready;
  assign is_store  = (ex_mem_op == 2'b10);
  assign is_mem    = (ex_mem_op == 2'b01) | is_store;
  assign misal_now = ((ex_size == 2'b01) & ex_alu_result[0]) |
                     (ex_size[1] & (|ex_alu_result[1:0]));
  assign start_mem = accept & is_mem & ~misal_now;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mem) state_nxt = REQ;
      REQ:     if (dmem.dmem_gnt) state_nxt = we_p0 ? IDLE : WAIT;
      WAIT:    if (dmem.dmem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields are forced to zero outside REQ so nothing stale leaks onto the port.
  always_comb begin
    ex_ready        = (state == IDLE);
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'h0;
    dmem.dmem_be    = 4'h0;
    dmem.dmem_wdata = 32'h0;
    if (state == REQ) begin
      dmem.dmem_req   = 1'b1;
      dmem.dmem_we    = we_p0;
      dmem.dmem_addr  = {addr_p0[31:2], 2'b00};
      dmem.dmem_be    = be_p0;
      dmem.dmem_wdata = wdata_p0;
    end
  end

  // p0: access captured at accept, held for the whole request/response
  always_ff @(posedge clk) begin
    if (start_mem) begin
      addr_p0  <= ex_alu_result[31:0];
      size_p0  <= ex_size;
      uns_p0   <= ex_unsigned;
      rd_p0    <= ex_rd;
      wb_en_p0 <= ex_wb_en;
      we_p0    <= is_store;
      be_p0    <= byte_en(ex_size, ex_alu_result[1:0]);
      wdata_p0 <= lane_rep(ex_size, ex_store_data);
    end
  end

  // p1: registered writeback result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      mis_p1     <= 1'b0;
      wb_en_p1   <= 1'b0;
      wb_rd_p1   <= 5'd0;
      wb_data_p1 <= 32'h0;
    end else begin
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      wb_en_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (!is_mem || misal_now)) begin
            vld_p1     <= 1'b1;
            mis_p1     <= is_mem;
            wb_en_p1   <= ~is_mem & ex_wb_en;
            wb_rd_p1   <= ex_rd;
            wb_data_p1 <= ex_alu_result[31:0];
          end
        end
        REQ: begin
          if (dmem.dmem_gnt && we_p0) begin
            vld_p1   <= 1'b1;
            wb_rd_p1 <= rd_p0;
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            vld_p1     <= 1'b1;
            wb_en_p1   <= wb_en_p0;
            wb_rd_p1   <= rd_p0;
            wb_data_p1 <= load_extract(size_p0, uns_p0, addr_p0[1:0], dmem.dmem_rdata);
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_valid = vld_p1;
  assign misalign = mis_p1;
  assign wb_en    = wb_en_p1;
  assign wb_rd    = wb_rd_p1;
  assign wb_data  = wb_data_p1;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Load/store stage directly downstream of the execute ALU.
- Consumes the ALU result as the effective address, together with the store data and op controls from EX.
- Drives a request/grant/response data-memory port and stalls EX while an access is outstanding.
- Presents registered writeback results: load data (sign/zero extended) or ALU passthrough.

Parameters:
- DMEM_LATENCY_MIN, 1, minimum cycles from dmem_gnt to dmem_rvalid the stage relies on; fixed at 1, documentation only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage accepts EX instruction this cycle.
- ex_alu_result  in  33  ALU result; address/passthrough = bits [31:0], bit 32 ignored.
- ex_store_data  in  32  store source register.
- ex_mem_op  in  2  00 none (passthrough), 01 load, 10 store, 11 treated as none.
- ex_size  in  2  00 byte, 01 half, 10/11 word.
- ex_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
- ex_rd  in  5  destination register.
- ex_wb_en  in  1  instruction writes rd.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  memory accepts request.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse, result ready.
- wb_en  out  1  writeback enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- misalign  out  1  one-cycle pulse with wb_valid on misaligned access.

Behaviour:
- Reset: all outputs 0 except ex_ready = 1. State returns to IDLE, including mid-access. dmem_req drops in the cycle after rst. A dmem_rvalid/dmem_gnt from before reset is ignored.
- States: IDLE, REQ, WAIT.
- ex_ready = 1 only in IDLE. Accept = ex_valid & ex_ready.
- IDLE, accept, op none: next cycle wb_valid = 1, wb_data = ex_alu_result[31:0], wb_en = ex_wb_en, wb_rd = ex_rd. Stay IDLE. 1-cycle latency, back-to-back passthrough each cycle.
- IDLE, accept, load/store, misaligned (half with addr[0] = 1; word with addr[1:0] != 0): no request. Next cycle wb_valid = 1, misalign = 1, wb_en = 0. Stay IDLE.
- IDLE, accept, aligned load/store: latch addr, size, unsigned, rd, wb_en, data. Go to REQ with dmem_req = 1 from the next cycle.
- REQ: hold dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata stable until dmem_gnt.
  - On gnt, store: drop req, next cycle wb_valid = 1, wb_en = 0, go to IDLE.
  - On gnt, load: drop req, go to WAIT.
- WAIT: dmem_req = 0. On dmem_rvalid: next cycle wb_valid = 1, wb_en = latched wb_en, wb_data = extracted load, go to IDLE.
- dmem_rvalid in IDLE/REQ is ignored. Memory guarantees rvalid no earlier than the cycle after gnt.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- dmem_wdata:
  - byte: {4{data[7:0]}}.
  - half: {2{data[15:0]}}.
  - word: data.
- Load extract: shifted = dmem_rdata >> (8*addr[1:0]).
  - byte: low 8 bits.
  - half: low 16 bits.
  - word: all 32 bits.
  - Extend to 32 bits by ex_unsigned.
- Minimum latency, accept to wb_valid, with gnt in the first REQ cycle and rvalid the next cycle: store 2 cycles, load 3 cycles.
- ex_valid while ex_ready = 0: EX holds its inputs. This stage does not sample them.
- wb_valid/misalign are pulses and never held more than 1 cycle.

Test Plan:
- Passthrough: ex_alu_result = 33'h0_DEADBEEF, op none, wb_en = 1, rd = 5 for 3 consecutive cycles -> wb_valid each following cycle, wb_data = 32'hDEADBEEF, rd = 5, ex_ready constantly 1.
- Store byte: addr 0x1003, data 0x000000A5, gnt delayed 3 cycles -> dmem_addr = 0x1000, be = 4'b1000, wdata = 0xA5A5A5A5 stable 3 cycles. wb_valid with wb_en = 0 the cycle after gnt.
- Load half signed/unsigned: addr 0x2002, rdata 0x8001_1234 -> signed wb_data = 0xFFFF8001, unsigned 0x00008001. Latency 3 with immediate gnt/rvalid. ex_ready low for 2 cycles.
- Misaligned: word load at 0x3001 -> no dmem_req, misalign and wb_valid pulse next cycle with wb_en = 0.
- Stray rvalid in IDLE ignored. Reset asserted in WAIT -> req 0, ex_ready 1 after reset. Late rvalid produces no wb_valid.
- Byte load, addr 0x4001, rdata 0x11_22_F0_44, signed -> wb_data = 0xFFFFFFF0.
